// File: rtl/preproc_pkg.sv
// Shared definitions for the ADC pulse path: widths, detector states,
// sample bus layout {time, adc} and event record field offsets.
package preproc_pkg;

    localparam int DATA_W = 16;
    localparam int TIME_W = 64;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IN_PULSE = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_e;

    // Event record: {truncated, peak_time, peak_value, width}
    localparam int EV_WIDTH_LSB = 0;
    localparam int EV_PEAK_LSB  = 16;
    localparam int EV_TIME_LSB  = 32;
    localparam int EV_TRUNC_BIT = 96;
    localparam int EV_W         = 97;

    // Sample bus: {time, adc}
    localparam int SMP_ADC_LSB  = 0;
    localparam int SMP_TIME_LSB = 16;
    localparam int SMP_W        = 80;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_read_stage.sv
// FIFO drain front end: gates the read enable and aligns a valid flag with
// the standard-mode FIFO output, which lags rd_en by one cycle.
module fifo_read_stage #(
    parameter int DATA_W = 16,
    parameter int TIME_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable_i,
    input  logic                     fifo_empty_i,
    input  logic [TIME_W+DATA_W-1:0] fifo_dout_i,
    output logic                     rd_en_o,
    output logic                     sample_vld_o,
    output logic [DATA_W-1:0]        sample_adc_o,
    output logic [TIME_W-1:0]        sample_time_o
);

    logic sample_vld_q;

    // Reset term keeps the FIFO untouched while the detector is held in reset.
    assign rd_en_o = enable_i & ~fifo_empty_i & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sample_vld_q <= 1'b0;
        else        sample_vld_q <= rd_en_o;
    end

    assign sample_vld_o  = sample_vld_q;
    assign sample_adc_o  = fifo_dout_i[DATA_W-1:0];
    assign sample_time_o = fifo_dout_i[TIME_W+DATA_W-1:DATA_W];

endmodule

// File: rtl/pulse_event_detector.sv
// Threshold pulse detector: one record {truncated, peak_time, peak, width} per
// pulse into a single-entry slot. Define PULSE_TIMEOUT_EN for forced termination.
module pulse_event_detector #(
    parameter int          DATA_W    = 16,
    parameter int          TIME_W    = 64,
    parameter logic [15:0] MAX_WIDTH = 16'd4096
) (
    input  logic                        clk210_p,
    input  logic                        reset_n_p,
    input  logic                        enable_p,
    input  logic [DATA_W-1:0]           threshold_p,
    input  logic                        fifo_adc_empty_p,
    output logic                        fifo_adc_rd_en_p,
    input  logic [TIME_W+DATA_W-1:0]    fifo_adc_dout_p,
    output logic                        event_valid_p,
    input  logic                        event_ready_p,
    output logic [TIME_W+DATA_W+16:0]   event_data_p,
    output logic [15:0]                 events_dropped_p
);
    import preproc_pkg::*;

    localparam int REC_W = TIME_W + DATA_W + 17;

    logic              sample_vld;
    logic [DATA_W-1:0] sample_adc;
    logic [TIME_W-1:0] sample_time;
    logic              above;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic [TIME_W-1:0] ptime_q, ptime_d;
    logic [15:0]       width_q, width_d;
    logic              fin, trunc;
    logic              ev_valid_q, ev_valid_d;
    logic [REC_W-1:0]  ev_data_q, ev_data_d;
    logic [15:0]       dropped_q, dropped_d;
    logic              load, drop;

    fifo_read_stage #(.DATA_W(DATA_W), .TIME_W(TIME_W)) u_rd (
        .clk          (clk210_p),
        .rst_n        (reset_n_p),
        .enable_i     (enable_p),
        .fifo_empty_i (fifo_adc_empty_p),
        .fifo_dout_i  (fifo_adc_dout_p),
        .rd_en_o      (fifo_adc_rd_en_p),
        .sample_vld_o (sample_vld),
        .sample_adc_o (sample_adc),
        .sample_time_o(sample_time)
    );

    assign above = sample_adc > threshold_p;

    always_ff @(posedge clk210_p or negedge reset_n_p) begin
        if (!reset_n_p) begin
            state_q    <= ST_IDLE;
            peak_q     <= '0;
            ptime_q    <= '0;
            width_q    <= '0;
            ev_valid_q <= 1'b0;
            ev_data_q  <= '0;
            dropped_q  <= '0;
        end else begin
            state_q    <= state_d;
            peak_q     <= peak_d;
            ptime_q    <= ptime_d;
            width_q    <= width_d;
            ev_valid_q <= ev_valid_d;
            ev_data_q  <= ev_data_d;
            dropped_q  <= dropped_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sample_vld) begin
            case (state_q)
                ST_IDLE:     if (above) state_d = ST_IN_PULSE;
                ST_IN_PULSE: begin
                    if (!above) state_d = ST_IDLE;
`ifdef PULSE_TIMEOUT_EN
                    else if (width_d == MAX_WIDTH) state_d = ST_WAIT_LOW;
`endif
                end
                ST_WAIT_LOW: if (!above) state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath / finalise. The record is built from the *_d values: on a normal
    // termination they equal the held values, on a timeout they include the last sample.
    always_comb begin
        peak_d  = peak_q;
        ptime_d = ptime_q;
        width_d = width_q;
        fin     = 1'b0;
        trunc   = 1'b0;
        if (sample_vld) begin
            case (state_q)
                ST_IDLE: if (above) begin
                    peak_d  = sample_adc;
                    ptime_d = sample_time;
                    width_d = 16'd1;
                end
                ST_IN_PULSE: begin
                    if (above) begin
                        width_d = sat_inc(width_q);
                        if (sample_adc > peak_q) begin
                            peak_d  = sample_adc;
                            ptime_d = sample_time;
                        end
`ifdef PULSE_TIMEOUT_EN
                        if (width_d == MAX_WIDTH) begin
                            fin   = 1'b1;
                            trunc = 1'b1;
                        end
`endif
                    end else begin
                        fin = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef PULSE_TIMEOUT_EN
    logic unused_max_width;
    assign unused_max_width = ^MAX_WIDTH;
`endif

    always_comb begin
        load       = fin & (~ev_valid_q | event_ready_p);
        drop       = fin & ev_valid_q & ~event_ready_p;
        ev_valid_d = ev_valid_q & ~event_ready_p;
        ev_data_d  = ev_data_q;
        dropped_d  = drop ? sat_inc(dropped_q) : dropped_q;
        if (load) begin
            ev_valid_d = 1'b1;
            ev_data_d  = {trunc, ptime_d, peak_d, width_d};
        end
    end

    assign event_valid_p    = ev_valid_q;
    assign event_data_p     = ev_data_q;
    assign events_dropped_p = dropped_q;

endmodule
